ms_result_capture: RTL and testbench
====================================

Name: ms_result_capture

Overview:
- Upstream neighbour of the SPI result readout. Counts multi-slope modulator events during one conversion: PWM pattern periods NA/NB/PA/PB, rundown clocks, and the N64/P8/N1 slope steps.
- At end of conversion it publishes a coherent snapshot on the st* result buses.
- Publishing never happens while the SPI host has cs asserted, so a readout frame is never torn.

Parameters:
- PWM_W, 32, width of the four PWM period counters and stpwm* outputs.
- RD_W, 12, width of the rundown clock counter and strundown.
- SL_W, 8, width of the N64/P8/N1 step counters and stN64/stP8/stN1.
- SYNC_STAGES, 2, flip-flop stages synchronising cs into clk.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- conv_start  in  1  one-cycle pulse: begin integration.
- conv_abort  in  1  one-cycle pulse: discard the current conversion.
- pwm_na, pwm_nb, pwm_pa, pwm_pb  in  1 each  one-cycle pulse per completed PWM period of that pattern.
- rundown_start  in  1  one-cycle pulse: integration over, rundown begins.
- step_n64, step_p8, step_n1  in  1 each  one-cycle pulse per rundown slope step.
- comp_zero  in  1  one-cycle pulse: comparator crossing, rundown finished.
- cs  in  1  SPI chip select, asynchronous to clk; low means readout in progress.
- stpwmNA, stpwmNB, stpwmPA, stpwmPB  out  PWM_W  published PWM counts.
- strundown  out  RD_W  published rundown clock count.
- stN64, stP8, stN1  out  SL_W  published step counts.
- result_valid  out  1  one-cycle pulse when a snapshot is published.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky: conv_start arrived while a result was pending.
- sat  out  1  published snapshot contains a saturated counter.

Behaviour:
- Reset values:
  - all st* outputs 0; result_valid, busy, overrun, sat all 0.
  - working counters 0; state IDLE.
- cs path: synchronised through SYNC_STAGES flops to cs_s. rd_busy = !cs_s.
- FSM states: IDLE, INTEG, RUNDOWN, PUBLISH.
- IDLE:
  - on conv_start: clear all working counters and the working sat flag, then go to INTEG on the next cycle.
  - overrun is cleared on this same conv_start.
  - all other inputs are ignored.
- INTEG:
  - each pwm_* pulse increments its own counter by 1.
  - simultaneous pulses on different pwm_* inputs each increment their own counter in the same cycle.
  - rundown_start: go to RUNDOWN. A pwm pulse in that same cycle is still counted.
- RUNDOWN:
  - the rundown counter increments on every clk cycle spent in RUNDOWN, starting from the first cycle after rundown_start.
  - each step_* pulse increments its own counter.
  - comp_zero: go to PUBLISH. The rundown counter does not increment in the comp_zero cycle.
  - A step pulse coincident with comp_zero is counted.
- PUBLISH:
  - if rd_busy is 0: copy all working counters to st* and the working sat flag to sat; pulse result_valid high for exactly 1 cycle; go to IDLE.
  - if rd_busy is 1: hold in PUBLISH, st* unchanged.
  - conv_start received in PUBLISH sets overrun and is otherwise dropped.
  - Latency comp_zero -> result_valid is 2 cycles when cs is high.
- Saturation: every counter saturates at all-ones and never wraps. Any saturation sets the working sat flag.
- conv_abort:
  - in INTEG, RUNDOWN or PUBLISH: go to IDLE next cycle; working counters are dropped; st* and result_valid are untouched.
  - conv_abort has priority over every other event in the same cycle.
  - in IDLE it has no effect.
- st* outputs change only on the publish cycle; they are stable at all other times.
- Reset asserted mid-operation: immediate return to reset values. Any pending result is lost.

Decomposition:
- Shared package ms_pkg holds:
  - the FSM state enum (2-bit): IDLE, INTEG, RUNDOWN, PUBLISH.
  - default width constants PWM_W, RD_W, SL_W.
- One sub-module: ms_sync, an N-stage synchroniser with active-low asynchronous reset, used for cs.
  - cs flops reset to 1, i.e. not busy.
- Counters are a single saturating-increment function in ms_pkg. No counter sub-module.

Test Plan:
- Basic: conv_start; 5 pwm_na, 3 pwm_nb, 7 pwm_pa, 2 pwm_pb; rundown_start; 40 cycles; 4 step_n64, 1 step_p8, 9 step_n1; comp_zero; cs=1 -> stpwmNA=5, stpwmNB=3, stpwmPA=7, stpwmPB=2, strundown=40, stN64=4, stP8=1, stN1=9, sat=0; result_valid 1-cycle pulse 2 cycles after comp_zero.
- Readout hold-off: cs=0 at comp_zero, released 20 cycles later -> st* keep the previous snapshot until SYNC_STAGES+1 cycles after cs rises; then exactly one result_valid pulse.
- Overrun: cs held low, conv_start pulsed in PUBLISH -> overrun=1 and no new conversion starts; after cs rises, next conv_start from IDLE clears overrun.
- Abort: conv_abort during RUNDOWN after 10 cycles -> busy=0 next cycle; st* unchanged; no result_valid; next full conversion publishes correct fresh counts.
- Saturation: with SL_W=8, pulse step_n1 300 times -> stN1=255, sat=1; sat=0 after the next unsaturated conversion.
- Simultaneity and reset: pwm_na and pwm_pb in the same cycle as rundown_start -> both counted. rst_n low mid-INTEG -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/ms_pkg.sv
// Shared types, default widths and the saturating-increment helper for the
// multi-slope result capture block.
package ms_pkg;

    localparam int unsigned PWM_W = 32;
    localparam int unsigned RD_W  = 12;
    localparam int unsigned SL_W  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StInteg,
        StRundown,
        StPublish
    } ms_state_e;

    function automatic logic [63:0] all_ones(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Callers zero-extend to 64 bits and truncate the result back to their width.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned w,
                                            input logic en);
        return (en && (val != all_ones(w))) ? val + 64'd1 : val;
    endfunction

    function automatic logic sat_hit(input logic [63:0] val, input int unsigned w,
                                     input logic en);
        return en && (val == all_ones(w));
    endfunction

endpackage

// File: rtl/ms_result_capture_if.sv
// Event inputs, SPI chip select and published result bus of ms_result_capture.
interface ms_result_capture_if #(
    parameter int unsigned PWM_W = ms_pkg::PWM_W,
    parameter int unsigned RD_W  = ms_pkg::RD_W,
    parameter int unsigned SL_W  = ms_pkg::SL_W
);
    logic             conv_start;
    logic             conv_abort;
    logic             pwm_na;
    logic             pwm_nb;
    logic             pwm_pa;
    logic             pwm_pb;
    logic             rundown_start;
    logic             step_n64;
    logic             step_p8;
    logic             step_n1;
    logic             comp_zero;
    logic             cs;
    logic [PWM_W-1:0] stpwmNA;
    logic [PWM_W-1:0] stpwmNB;
    logic [PWM_W-1:0] stpwmPA;
    logic [PWM_W-1:0] stpwmPB;
    logic [RD_W-1:0]  strundown;
    logic [SL_W-1:0]  stN64;
    logic [SL_W-1:0]  stP8;
    logic [SL_W-1:0]  stN1;
    logic             result_valid;
    logic             busy;
    logic             overrun;
    logic             sat;

    modport master (
        output conv_start, conv_abort, pwm_na, pwm_nb, pwm_pa, pwm_pb, rundown_start,
               step_n64, step_p8, step_n1, comp_zero, cs,
        input  stpwmNA, stpwmNB, stpwmPA, stpwmPB, strundown, stN64, stP8, stN1,
               result_valid, busy, overrun, sat
    );

    modport slave (
        input  conv_start, conv_abort, pwm_na, pwm_nb, pwm_pa, pwm_pb, rundown_start,
               step_n64, step_p8, step_n1, comp_zero, cs,
        output stpwmNA, stpwmNB, stpwmPA, stpwmPB, strundown, stN64, stP8, stN1,
               result_valid, busy, overrun, sat
    );

endinterface

// File: rtl/ms_sync.sv
// N-stage flop synchroniser with a configurable reset level.
module ms_sync #(
    parameter int unsigned Stages   = 2,
    parameter logic        ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q, sync_d;

    // Truncating cast drops the oldest stage; also valid for a single stage.
    always_comb sync_d = Stages'({sync_q, d_i});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {Stages{ResetVal}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/ms_result_capture.sv
// Counts multi-slope modulator events over one conversion and publishes a coherent
// snapshot, holding publication off while the SPI host is reading.
module ms_result_capture #(
    parameter int unsigned PWM_W       = ms_pkg::PWM_W,
    parameter int unsigned RD_W        = ms_pkg::RD_W,
    parameter int unsigned SL_W        = ms_pkg::SL_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                clk,
    input logic                rst_n,
    ms_result_capture_if.slave bus
);
    import ms_pkg::*;

    ms_state_e        state_q, state_d;
    logic [PWM_W-1:0] pwm_q[4], pwm_d[4];
    logic [RD_W-1:0]  rd_q, rd_d;
    logic [SL_W-1:0]  sl_q[3], sl_d[3];
    logic             wsat_q, wsat_d;
    logic [PWM_W-1:0] st_pwm_q[4], st_pwm_d[4];
    logic [RD_W-1:0]  st_rd_q, st_rd_d;
    logic [SL_W-1:0]  st_sl_q[3], st_sl_d[3];
    logic             st_sat_q, st_sat_d;
    logic             overrun_q, overrun_d;
    logic             result_valid_q, result_valid_d;
    logic             cs_s, rd_busy;
    logic [3:0]       pwm_ev;
    logic [2:0]       sl_ev;

    ms_sync #(
        .Stages  (SYNC_STAGES),
        .ResetVal(1'b1)
    ) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (bus.cs),
        .q_o  (cs_s)
    );

    assign rd_busy = !cs_s;
    assign pwm_ev  = {bus.pwm_pb, bus.pwm_pa, bus.pwm_nb, bus.pwm_na};
    assign sl_ev   = {bus.step_n1, bus.step_p8, bus.step_n64};

    always_comb begin
        state_d        = state_q;
        pwm_d          = pwm_q;
        rd_d           = rd_q;
        sl_d           = sl_q;
        wsat_d         = wsat_q;
        st_pwm_d       = st_pwm_q;
        st_rd_d        = st_rd_q;
        st_sl_d        = st_sl_q;
        st_sat_d       = st_sat_q;
        overrun_d      = overrun_q;
        result_valid_d = 1'b0;
        // Abort beats every other event; working counters are simply left stale.
        if (bus.conv_abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.conv_start) begin
                        pwm_d     = '{default: '0};
                        rd_d      = '0;
                        sl_d      = '{default: '0};
                        wsat_d    = 1'b0;
                        overrun_d = 1'b0;
                        state_d   = StInteg;
                    end
                end
                StInteg: begin
                    for (int i = 0; i < 4; i++) begin
                        pwm_d[i] = PWM_W'(sat_inc(64'(pwm_q[i]), PWM_W, pwm_ev[i]));
                        if (sat_hit(64'(pwm_q[i]), PWM_W, pwm_ev[i])) wsat_d = 1'b1;
                    end
                    if (bus.rundown_start) state_d = StRundown;
                end
                StRundown: begin
                    for (int i = 0; i < 3; i++) begin
                        sl_d[i] = SL_W'(sat_inc(64'(sl_q[i]), SL_W, sl_ev[i]));
                        if (sat_hit(64'(sl_q[i]), SL_W, sl_ev[i])) wsat_d = 1'b1;
                    end
                    rd_d = RD_W'(sat_inc(64'(rd_q), RD_W, !bus.comp_zero));
                    if (sat_hit(64'(rd_q), RD_W, !bus.comp_zero)) wsat_d = 1'b1;
                    if (bus.comp_zero) state_d = StPublish;
                end
                StPublish: begin
                    if (bus.conv_start) overrun_d = 1'b1;
                    if (!rd_busy) begin
                        st_pwm_d       = pwm_q;
                        st_rd_d        = rd_q;
                        st_sl_d        = sl_q;
                        st_sat_d       = wsat_q;
                        result_valid_d = 1'b1;
                        state_d        = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            pwm_q          <= '{default: '0};
            rd_q           <= '0;
            sl_q           <= '{default: '0};
            wsat_q         <= 1'b0;
            st_pwm_q       <= '{default: '0};
            st_rd_q        <= '0;
            st_sl_q        <= '{default: '0};
            st_sat_q       <= 1'b0;
            overrun_q      <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pwm_q          <= pwm_d;
            rd_q           <= rd_d;
            sl_q           <= sl_d;
            wsat_q         <= wsat_d;
            st_pwm_q       <= st_pwm_d;
            st_rd_q        <= st_rd_d;
            st_sl_q        <= st_sl_d;
            st_sat_q       <= st_sat_d;
            overrun_q      <= overrun_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.stpwmNA      = st_pwm_q[0];
    assign bus.stpwmNB      = st_pwm_q[1];
    assign bus.stpwmPA      = st_pwm_q[2];
    assign bus.stpwmPB      = st_pwm_q[3];
    assign bus.strundown    = st_rd_q;
    assign bus.stN64        = st_sl_q[0];
    assign bus.stP8         = st_sl_q[1];
    assign bus.stN1         = st_sl_q[2];
    assign bus.sat          = st_sat_q;
    assign bus.overrun      = overrun_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_ms_result_capture.sv
// Self-checking bench for ms_result_capture: vector table plus scoreboard of
// expected snapshots, and hand-written hold-off/overrun/abort/reset sequences.
module tb_ms_result_capture;

    localparam int SYNC = 2;

    typedef struct packed {
        logic [31:0] na, nb, pa, pb;
        logic [11:0] rd;
        logic [7:0]  n64, p8, n1;
        logic        sat;
    } snap_t;

    typedef struct {
        int    na, nb, pa, pb, rdc, n64, p8, n1;
        bit    simul;
        snap_t exp;
    } vec_t;

    typedef struct {
        snap_t s;
        int    exp_cyc;
    } sb_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc_cnt = 0;
    int    valid_cnt = 0;
    sb_t   exp_q[$];
    sb_t   mon_e;
    snap_t last_pub = '0;
    vec_t  vecs[6];

    ms_result_capture_if #(.PWM_W(32), .RD_W(12), .SL_W(8)) bus ();

    ms_result_capture #(
        .PWM_W      (32),
        .RD_W       (12),
        .SL_W       (8),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic snap_t cur_snap();
        return {bus.stpwmNA, bus.stpwmNB, bus.stpwmPA, bus.stpwmPB, bus.strundown,
                bus.stN64, bus.stP8, bus.stN1, bus.sat};
    endfunction

    function automatic vec_t mk(input int na, nb, pa, pb, rdc, n64, p8, n1, input bit simul,
                                input int ena, enb, epa, epb, erd, e64, ep8, en1,
                                input bit esat);
        vec_t v;
        v.na = na; v.nb = nb; v.pa = pa; v.pb = pb;
        v.rdc = rdc; v.n64 = n64; v.p8 = p8; v.n1 = n1; v.simul = simul;
        v.exp = {32'(ena), 32'(enb), 32'(epa), 32'(epb), 12'(erd), 8'(e64), 8'(ep8),
                 8'(en1), esat};
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_snap(input string name, input snap_t act, input snap_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every result_valid pops one expected snapshot.
    always @(negedge clk) begin
        if (rst_n && bus.result_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got result_valid=1 required 0 (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk_snap("snapshot", cur_snap(), mon_e.s);
                if (mon_e.exp_cyc >= 0) chk("valid_latency", cyc_cnt, mon_e.exp_cyc);
                last_pub = mon_e.s;
            end
        end
    end

    task automatic run_conv(input vec_t v);
        int  np;
        sb_t e;
        bus.conv_start = 1'b1;
        step();
        bus.conv_start = 1'b0;
        np = v.na;
        if (v.nb > np) np = v.nb;
        if (v.pa > np) np = v.pa;
        if (v.pb > np) np = v.pb;
        for (int i = 0; i < np; i++) begin
            bus.pwm_na = (i < v.na);
            bus.pwm_nb = (i < v.nb);
            bus.pwm_pa = (i < v.pa);
            bus.pwm_pb = (i < v.pb);
            step();
        end
        bus.pwm_nb = 1'b0;
        bus.pwm_pa = 1'b0;
        bus.pwm_na = v.simul;
        bus.pwm_pb = v.simul;
        bus.rundown_start = 1'b1;
        step();
        bus.rundown_start = 1'b0;
        bus.pwm_na = 1'b0;
        bus.pwm_pb = 1'b0;
        for (int j = 0; j < v.rdc; j++) begin
            bus.step_n64 = (j < v.n64);
            bus.step_p8  = (j < v.p8);
            bus.step_n1  = (j < v.n1);
            step();
        end
        bus.step_n64 = 1'b0;
        bus.step_p8  = 1'b0;
        bus.step_n1  = 1'b0;
        bus.comp_zero = 1'b1;
        e.s = v.exp;
        e.exp_cyc = bus.cs ? cyc_cnt + 2 : -1;
        exp_q.push_back(e);
        step();
        bus.comp_zero = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            step();
            k++;
        end
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        step();
        step();
    endtask

    initial begin
        int c, v0, lat;
        bit seen;
        bus.conv_start = 1'b0; bus.conv_abort = 1'b0;
        bus.pwm_na = 1'b0; bus.pwm_nb = 1'b0; bus.pwm_pa = 1'b0; bus.pwm_pb = 1'b0;
        bus.rundown_start = 1'b0; bus.comp_zero = 1'b0;
        bus.step_n64 = 1'b0; bus.step_p8 = 1'b0; bus.step_n1 = 1'b0;
        bus.cs = 1'b1;

        vecs[0] = mk(5, 3, 7, 2, 40, 4, 1, 9, 0,  5, 3, 7, 2, 40, 4, 1, 9, 0);
        vecs[1] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[2] = mk(1, 1, 1, 1, 10, 3, 3, 3, 1,  2, 1, 1, 2, 10, 3, 3, 3, 0);
        vecs[3] = mk(20, 0, 0, 15, 300, 0, 0, 300, 0,  20, 0, 0, 15, 300, 0, 0, 255, 1);
        vecs[4] = mk(2, 4, 6, 8, 12, 12, 5, 0, 0, 2, 4, 6, 8, 12, 12, 5, 0, 0);
        vecs[5] = mk(0, 9, 0, 0, 0, 0, 0, 0, 0,   0, 9, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_snap("reset_st", cur_snap(), '0);
        chk("reset_flags", {bus.result_valid, bus.busy, bus.overrun}, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_conv(vecs[i]);
            wait_drain();
        end

        // Hold-off: snapshot must wait for cs to rise and pass the synchroniser.
        bus.cs = 1'b0;
        repeat (4) step();
        run_conv(vecs[0]);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("holdoff_valid", bus.result_valid, 0);
            chk_snap("holdoff_st", cur_snap(), last_pub);
            step();
        end
        v0 = valid_cnt;
        bus.cs = 1'b1;
        c = cyc_cnt;
        seen = 1'b0;
        lat = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (bus.result_valid) begin
                seen = 1'b1;
                lat = cyc_cnt - c;
            end
        end
        chk("holdoff_seen", seen, 1);
        chk("holdoff_latency", lat, SYNC + 1);
        repeat (5) step();
        chk("holdoff_pulses", valid_cnt - v0, 1);
        exp_q.delete();

        // Overrun: conv_start while PUBLISH is held off.
        bus.cs = 1'b0;
        repeat (4) step();
        run_conv(vecs[4]);
        repeat (3) step();
        bus.conv_start = 1'b1;
        step();
        bus.conv_start = 1'b0;
        @(negedge clk);
        chk("overrun_set", bus.overrun, 1);
        chk("overrun_still_publish", bus.busy, 1);
        step();
        bus.cs = 1'b1;
        wait_drain();
        @(negedge clk);
        chk("overrun_idle", bus.busy, 0);
        chk("overrun_sticky", bus.overrun, 1);
        step();
        bus.conv_start = 1'b1;
        step();
        bus.conv_start = 1'b0;
        @(negedge clk);
        chk("overrun_cleared", bus.overrun, 0);
        chk("overrun_new_conv", bus.busy, 1);
        step();
        bus.conv_abort = 1'b1;
        step();
        bus.conv_abort = 1'b0;

        // Abort during RUNDOWN.
        v0 = valid_cnt;
        bus.conv_start = 1'b1;
        step();
        bus.conv_start = 1'b0;
        bus.pwm_pa = 1'b1;
        repeat (3) step();
        bus.pwm_pa = 1'b0;
        bus.rundown_start = 1'b1;
        step();
        bus.rundown_start = 1'b0;
        bus.step_p8 = 1'b1;
        repeat (10) step();
        bus.step_p8 = 1'b0;
        bus.conv_abort = 1'b1;
        step();
        bus.conv_abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk_snap("abort_st", cur_snap(), last_pub);
        repeat (5) step();
        chk("abort_no_valid", valid_cnt - v0, 0);
        run_conv(vecs[1]);
        wait_drain();

        // Asynchronous reset mid-INTEG.
        bus.conv_start = 1'b1;
        step();
        bus.conv_start = 1'b0;
        bus.pwm_na = 1'b1;
        repeat (3) step();
        bus.pwm_na = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_snap("async_reset_st", cur_snap(), '0);
        chk("async_reset_flags", {bus.result_valid, bus.busy, bus.overrun}, 0);
        last_pub = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_conv(vecs[2]);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
